// File: rtl/parity_frame_unit.sv
// rtl/parity_frame_unit.sv - serial frame parity generator/checker with saturating mismatch counter
module parity_frame_unit #(
  parameter int DATA_BITS   = 8,
  parameter bit EVEN_PARITY = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  input  logic                 wr_en,
  input  logic                 check_en,
  input  logic                 clear,
  input  logic                 err_cnt_clr,
  output logic                 data_out,
  output logic                 parity_out,
  output logic                 parity_valid,
  output logic                 parity_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);
  localparam logic PAR_INV = ~EVEN_PARITY;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;

  state_t           state;
  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic             mode;

  logic acc_nxt, p_cur, done, done_p, mismatch;

  always_comb begin
    acc_nxt  = acc ^ data_in;
    p_cur    = acc ^ PAR_INV;
    done     = 1'b0;
    done_p   = acc_nxt ^ PAR_INV;
    mismatch = 1'b0;
    if (wr_en && !clear) begin
      case (state)
        S_IDLE: done = (DATA_BITS == 1) && !check_en;
        S_DATA: done = (cnt == LAST_CNT) && !mode;
        S_PAR: begin
          // the bit arriving here is the received parity, not data
          done     = 1'b1;
          done_p   = p_cur;
          mismatch = (data_in != p_cur);
        end
        default: done = 1'b0;
      endcase
    end
  end

  assign data_out = p_cur;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      acc          <= 1'b0;
      cnt          <= '0;
      mode         <= 1'b0;
      parity_out   <= PAR_INV;
      parity_valid <= 1'b0;
      parity_err   <= 1'b0;
      err_count    <= '0;
    end else begin
      parity_valid <= done;
      if (done) begin
        parity_out <= done_p;
        parity_err <= mismatch;
      end
      if (err_cnt_clr)
        err_count <= ERR_CNT_W'(mismatch);
      else if (mismatch && (err_count != '1))
        err_count <= err_count + ERR_CNT_W'(1);

      if (clear) begin
        state <= S_IDLE;
        acc   <= 1'b0;
        cnt   <= '0;
      end else if (wr_en) begin
        case (state)
          S_IDLE: begin
            mode <= check_en;
            if ((DATA_BITS == 1) && !check_en) begin
              acc   <= 1'b0;
              cnt   <= '0;
              state <= S_IDLE;
            end else begin
              acc   <= data_in;
              cnt   <= CNT_W'(1);
              state <= (DATA_BITS == 1) ? S_PAR : S_DATA;
            end
          end
          S_DATA: begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_nxt;
            if (cnt == LAST_CNT) begin
              if (mode) begin
                state <= S_PAR;
              end else begin
                state <= S_IDLE;
                acc   <= 1'b0;
                cnt   <= '0;
              end
            end
          end
          S_PAR: begin
            state <= S_IDLE;
            acc   <= 1'b0;
            cnt   <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_unit.sv
// tb/tb_parity_frame_unit.sv - self-checking bench for parity_frame_unit (three parameterisations, shared stimulus)
module tb_parity_frame_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_in = 1'b0, wr_en = 1'b0, check_en = 1'b0, clear = 1'b0, err_cnt_clr = 1'b0;
  logic dout [3];
  logic pout [3];
  logic pval [3];
  logic perr [3];
  logic bsy  [3];
  logic [1:0] ecnt [3];

  int checks = 0;
  int errors = 0;

  localparam int NB [3] = '{4, 4, 1};
  localparam int EV [3] = '{1, 0, 1};

  always #5 clk = ~clk;

  parity_frame_unit #(.DATA_BITS(4), .EVEN_PARITY(1), .ERR_CNT_W(2)) u_even4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .check_en(check_en),
    .clear(clear), .err_cnt_clr(err_cnt_clr), .data_out(dout[0]), .parity_out(pout[0]),
    .parity_valid(pval[0]), .parity_err(perr[0]), .busy(bsy[0]), .err_count(ecnt[0]));

  parity_frame_unit #(.DATA_BITS(4), .EVEN_PARITY(0), .ERR_CNT_W(2)) u_odd4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .check_en(check_en),
    .clear(clear), .err_cnt_clr(err_cnt_clr), .data_out(dout[1]), .parity_out(pout[1]),
    .parity_valid(pval[1]), .parity_err(perr[1]), .busy(bsy[1]), .err_count(ecnt[1]));

  parity_frame_unit #(.DATA_BITS(1), .EVEN_PARITY(1), .ERR_CNT_W(2)) u_even1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .check_en(check_en),
    .clear(clear), .err_cnt_clr(err_cnt_clr), .data_out(dout[2]), .parity_out(pout[2]),
    .parity_valid(pval[2]), .parity_err(perr[2]), .busy(bsy[2]), .err_count(ecnt[2]));

  // Reference model: frames as counts of accepted bits and of ones
  int m_active [3];
  int m_mode   [3];
  int m_ones   [3];
  int m_n      [3];
  int m_par    [3];
  int e_pout   [3];
  int e_pval   [3];
  int e_perr   [3];
  int e_ecnt   [3];

  function automatic int par_of(input int i, input int ones);
    return (EV[i] != 0) ? (ones % 2) : (1 - (ones % 2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_active[i] = 0; m_mode[i] = 0; m_ones[i] = 0; m_n[i] = 0; m_par[i] = 0;
      e_pout[i] = par_of(i, 0); e_pval[i] = 0; e_perr[i] = 0; e_ecnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int mis;
      int p;
      mis = 0;
      e_pval[i] = 0;
      if (clear) begin
        m_active[i] = 0; m_ones[i] = 0; m_n[i] = 0; m_par[i] = 0;
      end else if (wr_en) begin
        if (m_active[i] == 0) begin
          m_active[i] = 1;
          m_mode[i] = int'(check_en);
        end
        if (m_par[i] != 0) begin
          p = par_of(i, m_ones[i]);
          mis = (int'(data_in) != p) ? 1 : 0;
          e_pout[i] = p; e_pval[i] = 1; e_perr[i] = mis;
          m_active[i] = 0; m_ones[i] = 0; m_n[i] = 0; m_par[i] = 0;
        end else begin
          m_ones[i] += int'(data_in);
          m_n[i]++;
          if (m_n[i] == NB[i]) begin
            if (m_mode[i] != 0) begin
              m_par[i] = 1;
            end else begin
              e_pout[i] = par_of(i, m_ones[i]); e_pval[i] = 1; e_perr[i] = 0;
              m_active[i] = 0; m_ones[i] = 0; m_n[i] = 0;
            end
          end
        end
      end
      if (err_cnt_clr) e_ecnt[i] = mis;
      else if (mis != 0 && e_ecnt[i] < 3) e_ecnt[i]++;
    end
  endtask

  task automatic check(input string tag, input int i, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, ".data_out"},     i, 32'(dout[i]), par_of(i, m_ones[i]));
      check({tag, ".parity_out"},   i, 32'(pout[i]), e_pout[i]);
      check({tag, ".parity_valid"}, i, 32'(pval[i]), e_pval[i]);
      check({tag, ".parity_err"},   i, 32'(perr[i]), e_perr[i]);
      check({tag, ".busy"},         i, 32'(bsy[i]),  m_active[i]);
      check({tag, ".err_count"},    i, 32'(ecnt[i]), e_ecnt[i]);
    end
  endtask

  task automatic step(input logic w, input logic d, input logic c, input logic clr,
                      input logic ec, input string tag);
    wr_en = w; data_in = d; check_en = c; clear = clr; err_cnt_clr = ec;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1101;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // generate mode, back-to-back bits 1,0,1,1
    for (int b = 3; b >= 0; b--) step(1'b1, pat[b], 1'b0, 1'b0, 1'b0, "gen");
    check("gen_lit.parity_out", 0, 32'(pout[0]), 1);
    check("gen_lit.parity_out", 1, 32'(pout[1]), 0);
    check("gen_lit.parity_valid", 0, 32'(pval[0]), 1);
    idle(1);
    check("gen_lit.strobe_one_cycle", 0, 32'(pval[0]), 0);

    // same stream with gaps of 0..3 cycles between bits
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap"); idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap"); idle(3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "gap");
    check("gap_lit.parity_out", 1, 32'(pout[1]), 0);
    idle(2);

    // check mode: good parity then bad parity
    for (int b = 3; b >= 0; b--) step(1'b1, pat[b], 1'b1, 1'b0, 1'b0, "chk_good");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "chk_good_rx");
    check("chk_good_lit.err", 0, 32'(perr[0]), 0);
    for (int b = 3; b >= 0; b--) step(1'b1, pat[b], 1'b1, 1'b0, 1'b0, "chk_bad");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "chk_bad_rx");
    check("chk_bad_lit.err", 0, 32'(perr[0]), 1);
    check("chk_bad_lit.err_count", 0, 32'(ecnt[0]), 1);

    // clear on the 3rd bit, then a clean 0,0,0,1 frame
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "abort");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "abort");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "abort_clr");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_clr");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_clr");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_clr");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "post_clr");
    check("clr_lit.parity_out", 0, 32'(pout[0]), 1);
    check("clr_lit.err_count", 0, 32'(ecnt[0]), 1);

    // saturation of the 2-bit counter
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ecnt_clr");
    check("ecnt_clr_lit", 0, 32'(ecnt[0]), 0);
    for (int f = 0; f < 5; f++) begin
      for (int b = 3; b >= 0; b--) step(1'b1, pat[b], 1'b1, 1'b0, 1'b0, "sat");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sat_rx");
      check("sat_lit.err_count", 0, 32'(ecnt[0]), (f < 3) ? f + 1 : 3);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ecnt_clr2");
    check("ecnt_clr2_lit", 0, 32'(ecnt[0]), 0);

    // asynchronous reset mid-frame
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "pre_rst");
    wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    pat = 4'b1110;
    for (int b = 3; b >= 0; b--) step(1'b1, pat[b], 1'b0, 1'b0, 1'b0, "post_rst");
    check("post_rst_lit.parity_out", 0, 32'(pout[0]), 1);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(1'(($urandom_range(0, 3) != 0)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'(($urandom_range(0, 15) == 0)),
           1'(($urandom_range(0, 15) == 0)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_unit.md
# parity_frame_unit

Parametrised serial parity generator/checker; the next generation of the single-bit parity generator. Accepts a serial bit stream qualified by `wr_en` (e.g. from the team's `shift_reg` data source), groups it into frames of `DATA_BITS` bits, and emits a registered parity result per frame. In check mode the frame carries one trailing received parity bit, which the block compares against the computed parity and counts mismatches. It sits between a serial data source and a framing/transmit or receive-status stage.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 1..255.
- `EVEN_PARITY`, 1: 1 = even parity (bit makes total ones even), 0 = odd.
- `ERR_CNT_W`, 8: width of the saturating error counter.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `data_in`  in  1  serial data bit, sampled when `wr_en`=1.
- `wr_en`  in  1  bit-valid qualifier; gaps of any length allowed.
- `check_en`  in  1  frame mode, sampled with the first bit of a frame: 0 = generate, 1 = check.
- `clear`  in  1  synchronous frame abort.
- `err_cnt_clr`  in  1  synchronous clear of `err_count`.
- `data_out`  out  1  running parity of data bits accepted so far in the current frame.
- `parity_out`  out  1  parity of the last completed frame; held.
- `parity_valid`  out  1  one-cycle completion strobe.
- `parity_err`  out  1  mismatch flag of the last completed frame; held.
- `busy`  out  1  frame in progress.
- `err_count`  out  ERR_CNT_W  saturating count of check-mode mismatches.

## Operation
- State machine: IDLE, DATA, PAR.
- Accumulator `acc` = XOR of accepted data bits; bit counter width ceil(log2(DATA_BITS+1)).
- IDLE: on `wr_en`, `acc`←`data_in`, count←1, latch `check_en` into mode register, go to DATA. If DATA_BITS=1, that bit completes the data phase immediately (see below).
- DATA: each `wr_en` does `acc`^=`data_in`, count+1. On the bit that makes count=DATA_BITS: generate mode → complete frame, go to IDLE; check mode → go to PAR.
- PAR: next `wr_en` bit is the received parity `rx`; complete frame, go to IDLE.
- Computed parity `p` = EVEN_PARITY ? acc : ~acc (including the final data bit).
- Frame completion (registered): `parity_out`←`p`; `parity_valid`=1 for one cycle; `parity_err`←(check mode ? `rx`≠`p` : 0); on a mismatch, `err_count`+1, saturating at all-ones.
- `data_out` = EVEN_PARITY ? acc : ~acc, continuously updated from the registered `acc`. `acc` and count reset to 0 on completion.
- `busy` = 1 in DATA or PAR.
- `clear`: state→IDLE, acc and count→0, and the in-flight bit is discarded. `parity_out`, `parity_err` and `err_count` are unaffected. `clear` wins over a simultaneous `wr_en`.
- `err_cnt_clr`: `err_count`→0. If a mismatch completes in the same cycle, the result is 1.
- `check_en` changes mid-frame are ignored.

## Timing
- Reset values: state IDLE, `data_out`=~EVEN_PARITY (0 even, 1 odd), `parity_out`=~EVEN_PARITY, `parity_valid`=0, `parity_err`=0, `busy`=0, `err_count`=0.
- Latency: the last accepted bit is sampled at edge N. At edge N `parity_valid`, `parity_out` and `parity_err` update, so they are visible in cycle N+1. `busy` falls in the same cycle.
- Back-to-back: `wr_en` in the cycle after the final bit starts a new frame with no dead cycle. The strobe of the previous frame coincides with that frame's first bit.
- Reset asserted mid-frame: immediate return to reset values and the partial frame is lost. After deassertion the first `wr_en` starts a fresh frame.
- No throughput limit: one bit per clock is sustained indefinitely.

## Test plan
- DATA_BITS=4, EVEN_PARITY=1, generate mode, bits 1,0,1,1 on consecutive cycles -> `parity_valid` pulse 1 cycle after the 4th bit, `parity_out`=1, `parity_err`=0; `data_out` sequence 1,1,0,1.
- Same stream with EVEN_PARITY=0 and `wr_en` gaps of 0–3 cycles between bits -> `parity_out`=0, exactly one strobe, `busy` high from the first bit until the strobe.
- Check mode, DATA_BITS=4, EVEN_PARITY=1: frame 1,0,1,1,+1 -> `parity_err`=0, `err_count`=0. Then frame 1,0,1,1,+0 -> `parity_err`=1, `err_count`=1.
- `clear` asserted together with the 3rd bit of a frame, followed by a full 0,0,0,1 frame -> a single strobe with `parity_out`=1. The aborted bits have no effect and `err_count` is unchanged.
- ERR_CNT_W=2: 5 consecutive mismatching check frames -> `err_count` goes 1,2,3,3,3. `err_cnt_clr` then gives 0.
- `rst_n` pulsed low after the 2nd bit -> all outputs at reset values asynchronously. The next 4-bit frame 1,1,1,0 gives `parity_out`=1.
